imem_loader_ctrl: RTL and testbench

Sequencer and port owner for the CPU's 16-entry instruction memory. It holds the core in reset while it clears the memory and then loads a program from a valid/ready word stream, and only then releases the core. In RUN it passes the fetch-stage address straight through to the memory. It sits between the loader, the fetch stage and the memory's single combinational port, and is the only driver of that port.

---
 rtl/imem_loader_ctrl_pkg.sv | 20 ++
 rtl/imem_loader_ctrl_if.sv | 30 +++
 rtl/imem_loader_ctrl.sv | 119 +++++++++++
 tb/tb_imem_loader_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_ctrl_pkg.sv
// Shared types and constants for the instruction-memory loader, the memory
// and the fetch stage.
package imem_ctrl_pkg;

    localparam int IMEM_DATA_W = 16;
    localparam int IMEM_ADDR_W = 16;
    localparam int IMEM_DEPTH  = 16;

    localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_FINISH,
        ST_RUN,
        ST_ERR
    } imem_ctrl_state_t;

endpackage

// File: rtl/imem_loader_ctrl_if.sv
// Loader word stream and single-port instruction memory bus.
// The master side drives the request fields.
interface imem_ld_if
    import imem_ctrl_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    modport master (output ld_valid, ld_data, ld_last, input ld_ready);
    modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

interface imem_mem_if
    import imem_ctrl_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (output mem_addr, mem_wr_en, mem_wr_data, input mem_rd_data);
    modport slave  (input mem_addr, mem_wr_en, mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/imem_loader_ctrl.sv
// Owns the instruction memory port: clears it, loads a program from the
// loader stream, then releases the core and hands the port to fetch.
module imem_loader_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_start,
    input  logic                     run_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic [DATA_W-1:0]        fetch_instr,
    output logic                     fetch_stall,
    output logic                     core_run,
    output logic                     loading,
    output logic                     load_err,
    output logic [$clog2(DEPTH):0]   words_loaded,
    imem_ld_if.slave                 ld,
    imem_mem_if.master               mem
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam int WRD_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    imem_ctrl_state_t   state_q, state_d;
    logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [WRD_W-1:0]   words_q, words_d;
    logic               hs;
    logic               run;

    assign run = (state_q == ST_RUN);
    assign hs  = (state_q == ST_LOAD) && ld.ld_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            words_q   <= words_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        words_d   = words_q;

        // A start request always wins, even over a same-cycle handshake;
        // the only state that lets its final write finish first is FINISH.
        if (ld_start && state_q != ST_FINISH) begin
            state_d   = ST_CLEAR;
            wr_addr_d = '0;
            cnt_d     = '0;
            wr_en_d   = 1'b1;
            wr_data_d = DATA_W'(NOP_INSTR);
            words_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_req) state_d = ST_RUN;
                end
                ST_CLEAR: begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + CNT_W'(1);
                        wr_en_d   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        wr_addr_d = cnt_q;
                        wr_data_d = ld.ld_data;
                        wr_en_d   = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                        words_d   = words_q + WRD_W'(1);
                        if (ld.ld_last)               state_d = ST_FINISH;
                        else if (cnt_q == LAST_ADDR)  state_d = ST_ERR;
                    end
                end
                ST_FINISH: state_d = ST_RUN;
                default: ;
            endcase
        end
    end

    assign ld.ld_ready     = (state_q == ST_LOAD);
    assign core_run        = run;
    assign fetch_stall     = !run;
    assign fetch_instr     = run ? mem.mem_rd_data : DATA_W'(NOP_INSTR);
    assign loading         = (state_q == ST_CLEAR) || (state_q == ST_LOAD) ||
                             (state_q == ST_FINISH);
    assign load_err        = (state_q == ST_ERR);
    assign words_loaded    = words_q;
    assign mem.mem_addr    = run ? fetch_addr : ADDR_W'(wr_addr_q);
    assign mem.mem_wr_en   = wr_en_q;
    assign mem.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Bench for imem_loader_ctrl: memory model, write log and expected
// clear/load sequences derived from the load rules.
module tb_imem_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_start, run_req;
    logic [15:0] fetch_addr;
    logic [15:0] fetch_instr;
    logic        fetch_stall, core_run, loading, load_err;
    logic [4:0]  words_loaded;

    imem_ld_if  #(.DATA_W(16))              ld_if ();
    imem_mem_if #(.DATA_W(16), .ADDR_W(16)) mem_if ();

    imem_loader_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .run_req(run_req),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
        .fetch_stall(fetch_stall), .core_run(core_run), .loading(loading),
        .load_err(load_err), .words_loaded(words_loaded),
        .ld(ld_if.slave), .mem(mem_if.master)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; int addr; int data; } wr_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    wr_t         wlog[$];
    int          hs_tag[$];
    logic [15:0] mem [16];
    logic [15:0] pre [16];
    logic [15:0] prog [16];

    // Memory model: combinational read, write on the clock edge.
    assign mem_if.mem_rd_data = (mem_if.mem_addr < 16) ? mem[mem_if.mem_addr[3:0]] : 16'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 16; i++) mem[i] <= pre[i];
        end else if (mem_if.mem_wr_en) begin
            wlog.push_back('{cyc, int'(mem_if.mem_addr), int'(mem_if.mem_wr_data)});
            if (mem_if.mem_addr < 16) mem[mem_if.mem_addr[3:0]] <= mem_if.mem_wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(output int s);
        wlog.delete();
        ld_start = 1'b1;
        s = cyc;
        step();
        ld_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit with_last, input bit throttle);
        int idx = 0;
        int g = 0;
        hs_tag.delete();
        while (idx < n && g < 400) begin
            ld_if.ld_valid = !throttle || (g % 3 == 0);
            ld_if.ld_data  = prog[idx];
            ld_if.ld_last  = with_last && (idx == n - 1);
            #1;
            if (ld_if.ld_valid && ld_if.ld_ready) begin
                hs_tag.push_back(cyc);
                idx++;
            end
            step();
            g++;
        end
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        n_checks++;
        if (idx !== n) begin
            n_fail++;
            $display("FAIL feed_timeout accepted %0d words, required %0d", idx, n);
        end
    endtask

    // Called in the cycle after the last handshake; verifies end state and
    // the full write sequence issued since the start request in cycle s.
    task automatic check_load(input int s, input int n, input bit overflow, input bit throttle);
        wr_t exp[$];
        wr_t act[$];
        if (hs_tag.size() != n) return;
        if (!overflow) begin
            n_checks++;
            if ({loading, core_run} !== 2'b10) begin
                n_fail++;
                $display("FAIL finish_state loading/core_run=%b required 10", {loading, core_run});
            end
            step();
            n_checks++;
            if ({core_run, fetch_stall, loading, words_loaded} !== {3'b100, 5'(n)}) begin
                n_fail++;
                $display("FAIL run_entry run/stall/loading/words=%b/%b/%b/%0d required 1/0/0/%0d",
                         core_run, fetch_stall, loading, words_loaded, n);
            end
        end else begin
            n_checks++;
            if ({load_err, core_run, ld_if.ld_ready, words_loaded} !== {3'b100, 5'd16}) begin
                n_fail++;
                $display("FAIL err_entry err/run/ready/words=%b/%b/%b/%0d required 1/0/0/16",
                         load_err, core_run, ld_if.ld_ready, words_loaded);
            end
            step();
        end
        n_checks++;
        if (throttle ? (hs_tag[0] < s + 17) : (hs_tag[0] != s + 17)) begin
            n_fail++;
            $display("FAIL first_handshake cycle %0d, LOAD entered at %0d", hs_tag[0], s + 17);
        end
        for (int i = 0; i < 16; i++) exp.push_back('{s + 1 + i, i, 0});
        for (int j = 0; j < n; j++) exp.push_back('{hs_tag[j] + 1, j, int'(prog[j])});
        foreach (wlog[k]) if (wlog[k].tag > s) act.push_back(wlog[k]);
        n_checks++;
        if (act.size() != exp.size()) begin
            n_fail++;
            $display("FAIL write_count got %0d writes, required %0d", act.size(), exp.size());
        end else begin
            foreach (exp[k]) begin
                n_checks++;
                if (act[k] != exp[k]) begin
                    n_fail++;
                    $display("FAIL write_seq[%0d] got cyc %0d addr %0d data %h, required cyc %0d addr %0d data %h",
                             k, act[k].tag, act[k].addr, act[k].data, exp[k].tag, exp[k].addr, exp[k].data);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_start = 1'b0; run_req = 1'b0; fetch_addr = 16'h0;
        ld_if.ld_valid = 1'b0; ld_if.ld_data = 16'h0; ld_if.ld_last = 1'b0;
        for (int i = 0; i < 16; i++) pre[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({core_run, fetch_stall, ld_if.ld_ready, loading, load_err, mem_if.mem_wr_en,
             fetch_instr, mem_if.mem_addr, mem_if.mem_wr_data, words_loaded} !== {6'b010000, 53'h0}) begin
            n_fail++;
            $display("FAIL reset_state run/stall/rdy/ld/err/we=%b%b%b%b%b%b instr=%h addr=%h wd=%h words=%0d required 010000 and zeros",
                     core_run, fetch_stall, ld_if.ld_ready, loading, load_err, mem_if.mem_wr_en,
                     fetch_instr, mem_if.mem_addr, mem_if.mem_wr_data, words_loaded);
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_run_req();
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        n_checks++;
        if ({core_run, fetch_stall, mem_if.mem_wr_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL run_req run/stall/we=%b%b%b required 100", core_run, fetch_stall, mem_if.mem_wr_en);
        end
        for (int a = 0; a < 4; a++) begin
            fetch_addr = 16'(a);
            #1;
            n_checks++;
            if (fetch_instr !== pre[a] || mem_if.mem_addr !== 16'(a)) begin
                n_fail++;
                $display("FAIL run_fetch[%0d] instr=%h addr=%h required %h/%h", a, fetch_instr, mem_if.mem_addr, pre[a], a);
            end
        end
    endtask

    task automatic check_fetch(input int n);
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 16'(a);
            #1;
            n_checks++;
            if (fetch_instr !== ((a < n) ? prog[a] : 16'h0)) begin
                n_fail++;
                $display("FAIL program_fetch[%0d] got %h required %h", a, fetch_instr, (a < n) ? prog[a] : 16'h0);
            end
        end
    endtask

    task automatic test_fixed_program();
        int s;
        prog[0] = 16'h2AF0; prog[1] = 16'h2B01; prog[2] = 16'hC123; prog[3] = 16'hF000;
        start_load(s);
        feed(4, 1'b1, 1'b0);
        check_load(s, 4, 1'b0, 1'b0);
        check_fetch(4);
    endtask

    task automatic test_throttled();
        int s;
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        start_load(s);
        feed(7, 1'b1, 1'b1);
        check_load(s, 7, 1'b0, 1'b1);
        check_fetch(7);
    endtask

    task automatic test_overflow();
        int s;
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        start_load(s);
        feed(16, 1'b0, 1'b0);
        check_load(s, 16, 1'b1, 1'b0);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        n_checks++;
        if ({load_err, core_run} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_hold err/run=%b%b required 10", load_err, core_run);
        end
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        start_load(s);
        n_checks++;
        if ({load_err, loading, words_loaded} !== {2'b01, 5'd0}) begin
            n_fail++;
            $display("FAIL err_restart err/loading/words=%b/%b/%0d required 0/1/0", load_err, loading, words_loaded);
        end
        feed(3, 1'b1, 1'b0);
        check_load(s, 3, 1'b0, 1'b0);
        check_fetch(3);
    endtask

    task automatic test_restart_in_load();
        int s;
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        start_load(s);
        feed(1, 1'b0, 1'b0);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = 16'hDEAD;
        ld_start = 1'b1;
        s = cyc;
        step();
        ld_start = 1'b0;
        ld_if.ld_valid = 1'b0;
        n_checks++;
        if ({mem_if.mem_wr_en, loading, mem_if.mem_addr, mem_if.mem_wr_data, words_loaded} !== {2'b11, 37'h0}) begin
            n_fail++;
            $display("FAIL load_restart we/loading/addr/wd/words=%b/%b/%h/%h/%0d required 1/1/0/0/0",
                     mem_if.mem_wr_en, loading, mem_if.mem_addr, mem_if.mem_wr_data, words_loaded);
        end
        feed(5, 1'b1, 1'b0);
        check_load(s, 5, 1'b0, 1'b0);
    endtask

    task automatic test_start_and_run_same_cycle();
        int s;
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        wlog.delete();
        ld_start = 1'b1;
        run_req  = 1'b1;
        s = cyc;
        step();
        ld_start = 1'b0;
        run_req  = 1'b0;
        n_checks++;
        if ({core_run, loading, mem_if.mem_wr_en, mem_if.mem_addr} !== {3'b011, 16'h0}) begin
            n_fail++;
            $display("FAIL start_beats_run run/loading/we/addr=%b/%b/%b/%h required 0/1/1/0",
                     core_run, loading, mem_if.mem_wr_en, mem_if.mem_addr);
        end
        feed(2, 1'b1, 1'b1);
        check_load(s, 2, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        int s;
        start_load(s);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_if.mem_wr_en, core_run, loading, ld_if.ld_ready, mem_if.mem_addr} !== 20'h0) begin
            n_fail++;
            $display("FAIL areset_clear we/run/loading/ready/addr=%b/%b/%b/%b/%h required all 0",
                     mem_if.mem_wr_en, core_run, loading, ld_if.ld_ready, mem_if.mem_addr);
        end
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) prog[i] = 16'($urandom);
        start_load(s);
        feed(3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_if.mem_wr_en, core_run, loading, ld_if.ld_ready, mem_if.mem_addr, words_loaded} !== 25'h0) begin
            n_fail++;
            $display("FAIL areset_load we/run/loading/ready/addr/words=%b/%b/%b/%b/%h/%0d required all 0",
                     mem_if.mem_wr_en, core_run, loading, ld_if.ld_ready, mem_if.mem_addr, words_loaded);
        end
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if ({core_run, loading, mem_if.mem_wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_idle run/loading/we=%b%b%b required 000", core_run, loading, mem_if.mem_wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_run_req();
        test_fixed_program();
        test_throttled();
        test_overflow();
        test_restart_in_load();
        test_start_and_run_same_cycle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
